// File: rtl/sseg_bank_ctrl_if.sv
// Bus interface for sseg_bank_ctrl: single-cycle write/read strobes,
// register address, write data and the registered read-back path.
interface sseg_bank_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wr_data;
    logic [7:0]        rd_data;
    logic              rd_valid;

    modport master (
        output wr_en, rd_en, addr, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/sseg_bank_ctrl.sv
// sseg_bank_ctrl: N-digit seven-segment register bank with per-digit hex
// decode, per-digit blink and registered read-back.
// Register map: DIGIT[0..N-1], BLINK_MASK at N, CTRL at N+1 (bit0 EN, bit1 HEX).
// Optional feature macro LZ_BLANK_EN: leading-zero blanking in HEX mode,
// enabled at run time by CTRL bit2.
module sseg_bank_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 5,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    sseg_bank_ctrl_if.slave         bus,
    output logic [8*NUM_DIGITS-1:0] sseg_export
);

    localparam int                CNT_W      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BLINK_DIV - 1);
    localparam logic [ADDR_W-1:0] MASK_ADDR  = ADDR_W'(NUM_DIGITS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(NUM_DIGITS + 1);
    // Only the mask bits that correspond to existing digits are storable.
    localparam logic [7:0]        MASK_VALID = (NUM_DIGITS >= 8) ? 8'hFF
                                               : 8'((1 << NUM_DIGITS) - 1);

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_t;

    logic [7:0]              digit_q [NUM_DIGITS];
    logic [7:0]              blink_mask_q;
    logic                    ctrl_en_q;
    logic                    ctrl_hex_q;
    logic                    ctrl_lz;
    logic [CNT_W-1:0]        blink_cnt_q;
    logic                    cnt_wrap;
    phase_t                  phase_q;
    phase_t                  phase_d;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [7:0]              rd_mux_p0;
    logic [7:0]              rd_data_p1;
    logic                    rd_vld_p1;
    logic [8*NUM_DIGITS-1:0] seg_p0;

    // Active-low gfedcba pattern for a hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Segment byte for one digit before blink/blanking overrides.
    function automatic logic [7:0] seg_encode(input logic [7:0] d, input logic en,
                                              input logic hex);
        logic [7:0] s;
        if (!en)       s = 8'hFF;
        else if (!hex) s = ~d;
        else           s = {~d[7], hex7(d[3:0])};
        return s;
    endfunction

    assign cnt_wrap = (blink_cnt_q == CNT_LAST);

    // Register bank writes; unmapped addresses fall through untouched.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= 8'h00;
            blink_mask_q <= 8'h00;
            ctrl_en_q    <= 1'b1;
            ctrl_hex_q   <= 1'b1;
        end else if (bus.wr_en) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (bus.addr == ADDR_W'(k)) digit_q[k] <= bus.wr_data;
            end
            if (bus.addr == MASK_ADDR) blink_mask_q <= bus.wr_data & MASK_VALID;
            if (bus.addr == CTRL_ADDR) begin
                ctrl_en_q  <= bus.wr_data[0];
                ctrl_hex_q <= bus.wr_data[1];
            end
        end
    end

`ifdef LZ_BLANK_EN
    logic lz_leading;

    // Run-time enable for leading-zero blanking (CTRL bit2).
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)                          ctrl_lz <= 1'b0;
        else if (bus.wr_en && bus.addr == CTRL_ADDR) ctrl_lz <= bus.wr_data[2];
    end

    // Blank zero digits from the top down until the first significant one; digit 0 always shows.
    always_comb begin
        lz_blank   = '0;
        lz_leading = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lz_leading && digit_q[k][3:0] == 4'h0 && !digit_q[k][7]) lz_blank[k] = 1'b1;
            else                                                        lz_leading = 1'b0;
        end
        if (!(ctrl_lz && ctrl_hex_q)) lz_blank = '0;
    end
`else
    assign ctrl_lz  = 1'b0;
    assign lz_blank = '0;
`endif

    // Free-running blink divider; runs whenever reset is released.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) blink_cnt_q <= '0;
        else if (cnt_wrap)  blink_cnt_q <= '0;
        else                blink_cnt_q <= blink_cnt_q + 1'b1;
    end

    // Blink phase state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) phase_q <= PH_ON;
        else                phase_q <= phase_d;
    end

    // Blink phase next state: toggle each time the divider wraps.
    always_comb begin
        phase_d = phase_q;
        if (cnt_wrap) phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
    end

    // Read-back mux; unmapped addresses return zero.
    always_comb begin
        rd_mux_p0 = 8'h00;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bus.addr == ADDR_W'(k)) rd_mux_p0 = digit_q[k];
        end
        if (bus.addr == MASK_ADDR) rd_mux_p0 = blink_mask_q;
        if (bus.addr == CTRL_ADDR) rd_mux_p0 = {5'b0, ctrl_lz, ctrl_hex_q, ctrl_en_q};
    end

    // Read stage: captures pre-write contents, so a same-cycle write is not visible.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_data_p1 <= 8'h00;
            rd_vld_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= bus.rd_en;
            if (bus.rd_en) rd_data_p1 <= rd_mux_p0;
        end
    end

    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = rd_vld_p1;

    // Per-digit segment pattern with blink and leading-zero overrides.
    always_comb begin
        seg_p0 = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            logic blink_bit;
            blink_bit = (k < 8) ? blink_mask_q[k[2:0]] : 1'b0;
            seg_p0[8*k +: 8] = seg_encode(digit_q[k], ctrl_en_q, ctrl_hex_q);
            if (lz_blank[k] || (blink_bit && phase_q == PH_OFF)) seg_p0[8*k +: 8] = 8'hFF;
        end
    end

    // Output stage: registered segment drive, all segments off in reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) sseg_export <= '1;
        else                sseg_export <= seg_p0;
    end

endmodule

// File: tb/tb_sseg_bank_ctrl.sv
// Testbench for sseg_bank_ctrl: directed scenarios plus randomized bus
// traffic checked against a register-level reference model.
module tb_sseg_bank_ctrl;

    localparam int ND = 4;
    localparam int AW = 5;
    localparam int BD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8*ND-1:0] sseg;

    always #5 clk = ~clk;

    sseg_bank_ctrl_if #(.ADDR_W(AW)) bus ();

    sseg_bank_ctrl #(
        .NUM_DIGITS (ND),
        .ADDR_W     (AW),
        .BLINK_DIV  (BD)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .sseg_export   (sseg)
    );

    // Reference model state
    logic [7:0] m_digit [ND];
    logic [7:0] m_mask;
    logic       m_en, m_hex, m_lz;
    int         n_edges;
    logic [6:0] hex_tab [16];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void m_reset();
        for (int k = 0; k < ND; k++) m_digit[k] = 8'h00;
        m_mask  = 8'h00;
        m_en    = 1'b1;
        m_hex   = 1'b1;
        m_lz    = 1'b0;
        n_edges = 0;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a < ND)      return m_digit[a];
        if (a == ND)     return m_mask;
        if (a == ND + 1) return {5'b0, m_lz, m_hex, m_en};
        return 8'h00;
    endfunction

    function automatic void m_write(input int a, input logic [7:0] d);
        if (a < ND) m_digit[a] = d;
        else if (a == ND) m_mask = d & 8'((1 << ND) - 1);
        else if (a == ND + 1) begin
            m_en  = d[0];
            m_hex = d[1];
`ifdef LZ_BLANK_EN
            m_lz  = d[2];
`endif
        end
    endfunction

    // Display the model state implies, given the number of edges since reset release.
    function automatic logic [8*ND-1:0] m_seg();
        logic [8*ND-1:0] s;
        logic            on;
        int              top;
        on  = ((n_edges / BD) % 2) == 0;
        top = 0;
        for (int k = 0; k < ND; k++)
            if (m_digit[k][3:0] != 4'h0 || m_digit[k][7]) top = k;
        for (int k = 0; k < ND; k++) begin
            logic [7:0] b;
            if (!m_en)       b = 8'hFF;
            else if (!m_hex) b = ~m_digit[k];
            else             b = {~m_digit[k][7], hex_tab[m_digit[k][3:0]]};
            if (m_en && m_hex && m_lz && k > top) b = 8'hFF;
            if (m_mask[k] && !on) b = 8'hFF;
            s[8*k +: 8] = b;
        end
        return s;
    endfunction

    // One bus cycle: drive strobes, advance one edge, check against the model.
    task automatic step(input logic we, input logic re, input int a, input logic [7:0] d);
        logic [8*ND-1:0] exp_seg;
        logic [7:0]      exp_rd;
        bus.wr_en   = we;
        bus.rd_en   = re;
        bus.addr    = a[AW-1:0];
        bus.wr_data = d;
        exp_seg = m_seg();
        exp_rd  = m_read(a);
        if (we) m_write(a, d);
        @(posedge clk);
        #1;
        n_edges++;
        chk("sseg", 32'(sseg), 32'(exp_seg));
        chk("rd_valid", 32'(bus.rd_valid), 32'(re));
        if (re) chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sseg"}, 32'(sseg), 32'hFFFF_FFFF);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'h0);
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = 8'h00;
        m_reset();
        #22;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_sseg", 32'(sseg), 32'hFFFF_FFFF);

        // Reset CTRL read-back
        step(1'b0, 1'b1, ND + 1, 8'h00);
        chk("ctrl_reset", 32'(bus.rd_data), 32'h03);

        // Hex decode with decimal point
        step(1'b1, 1'b0, 0, 8'h05);
        step(1'b1, 1'b0, 3, 8'h8A);
        idle(1);
        chk("hex_d0", 32'(sseg[7:0]), 32'h92);
        chk("hex_d3", 32'(sseg[31:24]), 32'h08);

        // Raw mode, then disabled
        step(1'b1, 1'b0, ND + 1, 8'h01);
        step(1'b1, 1'b0, 1, 8'h3C);
        idle(1);
        chk("raw_d1", 32'(sseg[15:8]), 32'hC3);
        step(1'b1, 1'b0, ND + 1, 8'h00);
        idle(1);
        chk("disabled", 32'(sseg), 32'hFFFF_FFFF);

        // Blink on digit 1
        step(1'b1, 1'b0, ND + 1, 8'h03);
        step(1'b1, 1'b0, ND, 8'h02);
        step(1'b1, 1'b0, 1, 8'h01);
        idle(3 * BD);

        // Same-cycle read and write to one address
        step(1'b1, 1'b0, 2, 8'h07);
        step(1'b1, 1'b1, 2, 8'h09);
        chk("rw_old", 32'(bus.rd_data), 32'h07);
        step(1'b0, 1'b1, 2, 8'h00);
        chk("rw_new", 32'(bus.rd_data), 32'h09);

        // Unmapped address read and write
        step(1'b1, 1'b0, 20, 8'hAA);
        step(1'b0, 1'b1, 20, 8'h00);
        chk("unmapped", 32'(bus.rd_data), 32'h00);

`ifdef LZ_BLANK_EN
        step(1'b1, 1'b0, ND, 8'h00);
        step(1'b1, 1'b0, ND + 1, 8'h07);
        step(1'b1, 1'b0, 3, 8'h00);
        step(1'b1, 1'b0, 2, 8'h00);
        step(1'b1, 1'b0, 1, 8'h01);
        step(1'b1, 1'b0, 0, 8'h00);
        idle(1);
        chk("lz_word", 32'(sseg), 32'hFFFF_F9C0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                            : int'($urandom_range(0, ND + 1));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
        end

        // Asynchronous reset mid-cycle; strobes during reset are ignored
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        bus.wr_en   = 1'b1;
        bus.addr    = '0;
        bus.wr_data = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        check_reset_outputs("held");
        rst_n = 1'b1;
        m_reset();
        step(1'b0, 1'b1, 0, 8'h00);
        step(1'b0, 1'b1, ND + 1, 8'h00);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, ND + 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global timeout so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
